// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch program-counter block.
// Latency: n/a (type/constant definitions only).
// Backpressure: n/a.
`timescale 1ns/1ps
package fetch_pkg;

    // Default widths; the instruction-address width must match the ROM depth.
    localparam int A_DEF     = 10;
    localparam int OFF_W_DEF = 6;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    // Source selected for the PC register on the next edge.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_START,
        PC_JUMP,
        PC_BRANCH,
        PC_INC
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_if.sv
// Harness-facing bundle of the fetch sequencer: control requests in, PC and status out.
// Latency: n/a (wiring only); PcFault exists only when FETCH_PC_BOUNDS_EN is defined.
// Backpressure: Stall is the only hold mechanism; there is no valid/ready handshake.
`timescale 1ns/1ps
interface fetch_pc_if #(
    parameter int A     = 10,
    parameter int OFF_W = 6,
    parameter int CNT_W = 16
);
    logic             Start;
    logic [A-1:0]     StartAddr;
    logic             Stall;
    logic             Halt;
    logic             Jump;
    logic [A-1:0]     JumpTarget;
    logic             Branch;
    logic             Taken;
    logic [OFF_W-1:0] BranchOff;
    logic [A-1:0]     InstAddress;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;
`ifdef FETCH_PC_BOUNDS_EN
    logic             PcFault;
`endif

    // Harness / decode side: drives requests, observes PC and status.
    modport master (
        output Start, StartAddr, Stall, Halt, Jump, JumpTarget, Branch, Taken, BranchOff,
        input  InstAddress, Running, Done, CycleCount
`ifdef FETCH_PC_BOUNDS_EN
        , input PcFault
`endif
    );

    // Sequencer side.
    modport slave (
        input  Start, StartAddr, Stall, Halt, Jump, JumpTarget, Branch, Taken, BranchOff,
        output InstAddress, Running, Done, CycleCount
`ifdef FETCH_PC_BOUNDS_EN
        , output PcFault
`endif
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC mux: hold, start address, absolute jump, PC + sign-extended offset, or PC + 1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a stall is expressed by the caller selecting PC_HOLD.
`timescale 1ns/1ps
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int A     = A_DEF,
    parameter int OFF_W = OFF_W_DEF
) (
    input  pc_sel_t          sel,
    input  logic [A-1:0]     pc,
    input  logic [A-1:0]     start_addr,
    input  logic [A-1:0]     jump_target,
    input  logic [OFF_W-1:0] branch_off,
    output logic [A-1:0]     next_pc
);

    // Sign-extended offset; the A-bit add wraps silently in both directions.
    logic [A-1:0] off_ext;
    assign off_ext = {{(A-OFF_W){branch_off[OFF_W-1]}}, branch_off};

    // Select the next PC value.
    always_comb begin
        next_pc = pc;
        unique case (sel)
            PC_HOLD:   next_pc = pc;
            PC_START:  next_pc = start_addr;
            PC_JUMP:   next_pc = jump_target;
            PC_BRANCH: next_pc = pc + off_ext;
            PC_INC:    next_pc = pc + A'(1);
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_pc.sv
// PC/fetch sequencer driving the combinational instruction ROM; optional bounds check via FETCH_PC_BOUNDS_EN.
// Latency: InstAddress is registered; first valid address one cycle after an accepted Start.
// Backpressure: Stall holds PC and state for the cycle while CycleCount keeps counting.
`timescale 1ns/1ps
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int A        = A_DEF,
    parameter int OFF_W    = OFF_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
`ifdef FETCH_PC_BOUNDS_EN
    ,
    parameter int PROG_LEN = 2**A
`endif
) (
    input logic       Clk,
    input logic       Reset_n,
    fetch_pc_if.slave bus
);

    fetch_state_t   state_q;
    fetch_state_t   state_nom;
    fetch_state_t   state_d;
    pc_sel_t        sel;
    logic           start_acc;
    logic           bound_hit;
    logic [A-1:0]   pc_q;
    logic [A-1:0]   next_pc;
    logic           running_q;
    logic           done_q;
    logic [CNT_W-1:0] cnt_q;

    // Next-state and PC-source selection; RUN priority is Stall > Halt > Jump > taken Branch > increment.
    always_comb begin
        sel       = PC_HOLD;
        state_nom = state_q;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                if (bus.Start) begin
                    sel       = PC_START;
                    state_nom = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (bus.Stall) begin
                    sel = PC_HOLD;
                end else if (bus.Halt) begin
                    sel       = PC_HOLD;
                    state_nom = HALTED;
                end else if (bus.Jump) begin
                    sel = PC_JUMP;
                end else if (bus.Branch && bus.Taken) begin
                    sel = PC_BRANCH;
                end else begin
                    sel = PC_INC;
                end
            end
            default: state_nom = IDLE;
        endcase
    end

    fetch_next_pc #(
        .A     (A),
        .OFF_W (OFF_W)
    ) u_next_pc (
        .sel         (sel),
        .pc          (pc_q),
        .start_addr  (bus.StartAddr),
        .jump_target (bus.JumpTarget),
        .branch_off  (bus.BranchOff),
        .next_pc     (next_pc)
    );

`ifdef FETCH_PC_BOUNDS_EN
    localparam logic [A:0] PROG_LIM = PROG_LEN[A:0];

    // A moving PC that would leave the program stops the core instead of fetching garbage.
    always_comb begin
        bound_hit = (state_q == RUN)
                 && (sel == PC_JUMP || sel == PC_BRANCH || sel == PC_INC)
                 && ({1'b0, next_pc} >= PROG_LIM);
    end
`else
    assign bound_hit = 1'b0;
`endif

    assign state_d = bound_hit ? HALTED : state_nom;

    // State, PC and registered status flags; reset aborts any run immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == HALTED);
            if (!bound_hit) begin
                pc_q <= next_pc;
            end
        end
    end

    // Run-cycle counter: cleared on an accepted Start, counts every RUN cycle, saturates at all-ones.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if (start_acc) begin
            cnt_q <= '0;
        end else if (state_q == RUN && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef FETCH_PC_BOUNDS_EN
    logic fault_q;

    // Sticky fault flag, cleared only by reset or the next accepted Start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fault_q <= 1'b0;
        end else if (start_acc) begin
            fault_q <= 1'b0;
        end else if (bound_hit) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.PcFault = fault_q;
`endif

    assign bus.InstAddress = pc_q;
    assign bus.Running     = running_q;
    assign bus.Done        = done_q;
    assign bus.CycleCount  = cnt_q;

endmodule
